// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state
// encodings, requester port indices and a small port-decode helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    logic [1:0] oh;
    if (port == PORT_DMA) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the DataMem port seen by the arbiter.
// slave = arbiter side, master = requesters/DataMem side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [31:0]       rdata0, rdata1;
  logic              mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that was not
// served last wins; a lone request is granted directly.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  // Grant index selection from the request pair and last winner
  always_comb begin
    grant = 1'b0;
    any   = req[0] | req[1];
    case (req)
      2'b11:   grant = ~last;
      2'b10:   grant = 1'b1;
      2'b01:   grant = 1'b0;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one combinational-read DataMem port between the MEM stage (port 0)
// and the DMA master (port 1); illegal addresses get an error ack instead.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 256,
  parameter int unsigned ADDR_W   = 32
) (
  input logic             clk,
  input logic             reset,
  dmem_arbiter_if.slave   bus
);

  localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_SIZE);

  state_e            state_r, state_nxt_s;
  logic              owner_r, rr_last_r;
  logic              we_r, err_flag_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [1:0]        ack_r, err_r;
  logic [31:0]       rdata0_r, rdata1_r;

  logic [1:0]        req_s;
  logic              grant_s, any_s;
  logic              cap_en_s, cap_port_s;
  logic              sel_we_s, sel_err_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_wdata_s, resp_data_s;

  assign req_s = {bus.req1, bus.req0};

  rr_arb2 u_rr_arb2 (
    .req   (req_s),
    .last  (rr_last_r),
    .grant (grant_s),
    .any   (any_s)
  );

  // Next-state and capture decision; RESP only hands over to the other port
  always_comb begin
    state_nxt_s = state_r;
    cap_en_s    = 1'b0;
    cap_port_s  = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          cap_en_s    = 1'b1;
          cap_port_s  = grant_s;
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (req_s[~owner_r]) begin
          cap_en_s    = 1'b1;
          cap_port_s  = ~owner_r;
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request mux for the port being captured
  always_comb begin
    sel_we_s    = bus.we0;
    sel_addr_s  = bus.addr0;
    sel_wdata_s = bus.wdata0;
    if (cap_port_s == PORT_DMA) begin
      sel_we_s    = bus.we1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      sel_we_s    = bus.we0;
      sel_addr_s  = bus.addr0;
      sel_wdata_s = bus.wdata0;
    end
  end

  assign sel_err_s   = (sel_addr_s >= RAM_LIMIT) || (sel_addr_s[1:0] != 2'b00);
  assign resp_data_s = (err_flag_r || we_r) ? 32'h0000_0000 : bus.mem_rdata;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Captured request; held outside ACCESS so the memory bus stays quiet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r    <= PORT_CPU;
      we_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h0000_0000;
      err_flag_r <= 1'b0;
    end else if (cap_en_s) begin
      owner_r    <= cap_port_s;
      we_r       <= sel_we_s;
      addr_r     <= sel_addr_s;
      wdata_r    <= sel_wdata_s;
      err_flag_r <= sel_err_s;
    end
  end

  // Round-robin history: reset value lets port 0 win the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_r <= PORT_DMA;
    end else if (state_r == ST_ACCESS) begin
      rr_last_r <= owner_r;
    end
  end

  // Per-port response registers: ack/err pulse during RESP, rdata held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_r    <= 2'b00;
      err_r    <= 2'b00;
      rdata0_r <= 32'h0000_0000;
      rdata1_r <= 32'h0000_0000;
    end else if (state_r == ST_ACCESS) begin
      ack_r <= port_onehot(owner_r);
      err_r <= err_flag_r ? port_onehot(owner_r) : 2'b00;
      if (owner_r == PORT_CPU) begin
        rdata0_r <= resp_data_s;
      end else begin
        rdata1_r <= resp_data_s;
      end
    end else begin
      ack_r <= 2'b00;
      err_r <= 2'b00;
    end
  end

  assign bus.ack0      = ack_r[0];
  assign bus.ack1      = ack_r[1];
  assign bus.err0      = err_r[0];
  assign bus.err1      = err_r[1];
  assign bus.rdata0    = rdata0_r;
  assign bus.rdata1    = rdata1_r;
  // Strobes decode from async-reset registers, so they fall the moment reset asserts
  assign bus.mem_rd    = (state_r == ST_ACCESS) && !we_r && !err_flag_r;
  assign bus.mem_wr    = (state_r == ST_ACCESS) &&  we_r && !err_flag_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle
// corner sequences, then random two-port traffic against a word-array model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32)) bus();

  dmem_arbiter #(.RAM_SIZE(256), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // DataMem stand-in: combinational read, write on negedge
  logic [31:0] bmem [64];
  logic        preloaded = 1'b0;
  always @(negedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 64; i++) bmem[i] <= 32'h0;
      bmem[2]   <= 32'hDEADBEEF;
      preloaded <= 1'b1;
    end else if (bus.mem_wr) begin
      bmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = bmem[bus.mem_addr[7:2]];

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_mem [64];

  typedef struct {
    int          p;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vt [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a);
    return (a >= 32'd256) || ((a % 32'd4) != 32'd0);
  endfunction

  function automatic logic ack_of(input int p);
    return (p == 0) ? bus.ack0 : bus.ack1;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? bus.err0 : bus.err1;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? bus.rdata0 : bus.rdata1;
  endfunction

  task automatic mon_check();
    if (bus.mem_rd || bus.mem_wr)
      check("strobe_legal", 32'(ref_err(bus.mem_addr) || (bus.mem_rd && bus.mem_wr)), 32'h0);
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One request from idle; called just after a posedge, returns just after a posedge
  task automatic run_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic e, output logic [31:0] rd,
                         output int nrd, output int nwr, output int nother);
    lat = 99; e = 1'b0; rd = 32'h0; nrd = 0; nwr = 0; nother = 0;
    drive(p, 1'b1, we, a, d);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      mon_check();
      if (bus.mem_rd) nrd++;
      if (bus.mem_wr) nwr++;
      if (ack_of(1 - p)) nother++;
      if (ack_of(p)) begin
        lat = c; e = err_of(p); rd = rdata_of(p);
        break;
      end
    end
    drive(p, 1'b0, we, a, d);
    @(posedge clk); #1;
  endtask

  int          lat, nrd, nwr, nother;
  logic        e;
  logic [31:0] rd;
  int          ack_port[$];
  int          ack_cyc[$];

  logic        act [2];
  int          idle [2];
  int          wt [2];
  logic        cwe [2];
  logic [31:0] cad [2];
  logic [31:0] cwd [2];

  initial begin
    vt[0]  = '{0, 1'b0, 32'd8,        32'h0,        1'b0, 32'hDEADBEEF};
    vt[1]  = '{1, 1'b1, 32'd12,       32'h12345678, 1'b0, 32'h0};
    vt[2]  = '{0, 1'b0, 32'd12,       32'h0,        1'b0, 32'h12345678};
    vt[3]  = '{0, 1'b0, 32'd256,      32'h0,        1'b1, 32'h0};
    vt[4]  = '{0, 1'b0, 32'd6,        32'h0,        1'b1, 32'h0};
    vt[5]  = '{1, 1'b1, 32'd255,      32'h11111111, 1'b1, 32'h0};
    vt[6]  = '{1, 1'b1, 32'd252,      32'hAABBCCDD, 1'b0, 32'h0};
    vt[7]  = '{1, 1'b0, 32'd252,      32'h0,        1'b0, 32'hAABBCCDD};
    vt[8]  = '{0, 1'b0, 32'hFFFFFF00, 32'h0,        1'b1, 32'h0};
    vt[9]  = '{0, 1'b1, 32'd0,        32'h55AA55AA, 1'b0, 32'h0};
    vt[10] = '{1, 1'b0, 32'd0,        32'h0,        1'b0, 32'h55AA55AA};
    vt[11] = '{1, 1'b0, 32'd4,        32'h0,        1'b0, 32'h0};
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    ref_mem[2] = 32'hDEADBEEF;

    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_ack0", 32'(bus.ack0), 32'h0);
    check("rst_ack1", 32'(bus.ack1), 32'h0);
    check("rst_err", 32'(bus.err0 | bus.err1), 32'h0);
    check("rst_rdata0", bus.rdata0, 32'h0);
    check("rst_rdata1", bus.rdata1, 32'h0);
    check("rst_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      run_req(vt[i].p, vt[i].we, vt[i].addr, vt[i].wdata, lat, e, rd, nrd, nwr, nother);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("v%0d_rd_cycles", i), 32'(nrd), 32'(!vt[i].we && !vt[i].exp_err));
      check($sformatf("v%0d_wr_cycles", i), 32'(nwr), 32'(vt[i].we && !vt[i].exp_err));
      check($sformatf("v%0d_other_ack", i), 32'(nother), 32'd0);
      if (vt[i].we && !vt[i].exp_err) ref_mem[vt[i].addr[7:2]] = vt[i].wdata;
    end

    // Contention from reset: both ports held high must alternate 0,1,0,1
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'd8, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd12, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      mon_check();
      check("cont_ack_exclusive", 32'(bus.ack0 && bus.ack1), 32'h0);
      if (bus.ack0) begin ack_port.push_back(0); ack_cyc.push_back(c); end
      if (bus.ack1) begin ack_port.push_back(1); ack_cyc.push_back(c); end
    end
    drive(0, 1'b0, 1'b0, 32'd8, 32'h0);
    drive(1, 1'b0, 1'b0, 32'd12, 32'h0);
    check("cont_ack_count_ge6", 32'(ack_port.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < ack_port.size(); i++)
      check($sformatf("cont_order%0d", i), 32'(ack_port[i]), 32'(i % 2));
    for (int i = 1; i < 6 && i < ack_cyc.size(); i++)
      check($sformatf("cont_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);
    repeat (2) begin @(posedge clk); #1; end

    // Owner held high through RESP: one ack every 3 cycles
    ack_cyc.delete();
    drive(0, 1'b1, 1'b0, 32'd8, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      mon_check();
      if (bus.ack0) ack_cyc.push_back(c);
    end
    drive(0, 1'b0, 1'b0, 32'd8, 32'h0);
    check("hold_ack_count", 32'(ack_cyc.size()), 32'd5);
    for (int i = 1; i < ack_cyc.size(); i++)
      check($sformatf("hold_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    repeat (2) begin @(posedge clk); #1; end

    // Reset asserted inside the ACCESS cycle of a write
    drive(1, 1'b1, 1'b1, 32'd16, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("ar_wr_in_access", 32'(bus.mem_wr), 32'd1);
    reset = 1'b0;
    #1;
    check("ar_wr_dropped", 32'(bus.mem_wr), 32'd0);
    check("ar_rd_low", 32'(bus.mem_rd), 32'd0);
    drive(1, 1'b0, 1'b0, 32'd16, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("ar_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    run_req(0, 1'b0, 32'd8, 32'h0, lat, e, rd, nrd, nwr, nother);
    check("ar_post_latency", 32'(lat), 32'd3);
    check("ar_post_rdata", rd, 32'hDEADBEEF);
    run_req(1, 1'b0, 32'd16, 32'h0, lat, e, rd, nrd, nwr, nother);
    check("ar_lost_write", rd, ref_mem[4]);

    // Random two-port traffic against the word-array model
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; idle[p] = p; wt[p] = 0;
      cwe[p] = 1'b0; cad[p] = 32'h0; cwd[p] = 32'h0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      mon_check();
      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          if (ack_of(p)) begin
            logic        xe;
            logic [31:0] xd;
            xe = ref_err(cad[p]);
            xd = (xe || cwe[p]) ? 32'h0 : ref_mem[cad[p][7:2]];
            check($sformatf("rnd_p%0d_err", p), 32'(err_of(p)), 32'(xe));
            check($sformatf("rnd_p%0d_rdata", p), rdata_of(p), xd);
            if (!xe && cwe[p]) ref_mem[cad[p][7:2]] = cwd[p];
            act[p] = 1'b0;
            drive(p, 1'b0, cwe[p], cad[p], cwd[p]);
            idle[p] = int'($urandom_range(0, 3));
          end else begin
            wt[p]++;
            if (wt[p] > 12) begin
              check($sformatf("rnd_p%0d_timeout", p), 32'(wt[p]), 32'd0);
              act[p] = 1'b0;
              drive(p, 1'b0, cwe[p], cad[p], cwd[p]);
            end
          end
        end else begin
          check($sformatf("rnd_p%0d_spurious_ack", p), 32'(ack_of(p)), 32'd0);
          if (idle[p] == 0) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7)       cad[p] = 32'($urandom_range(0, 63)) * 32'd4;
            else if (r == 7) cad[p] = 32'd256 + 32'($urandom_range(0, 1000)) * 32'd4;
            else             cad[p] = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
            cwe[p] = 1'($urandom_range(0, 1));
            cwd[p] = $urandom;
            act[p] = 1'b1;
            wt[p]  = 0;
            drive(p, 1'b1, cwe[p], cad[p], cwd[p]);
          end else begin
            idle[p]--;
          end
        end
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
